cv32e40p_x_acc_adapter: RTL and testbench
=========================================

CV32E40P_X_ACC_ADAPTER -- requirements
Module: cv32e40p_x_acc_adapter

Interface
REQ-001 Parameter FIFO_DEPTH, default 2: depth of the accepted-instruction FIFO; power of two, at least 2.
REQ-002 Parameter EXEC_LATENCY, default 3: execution cycles for ALU ops; at least 1.
REQ-003 The block SHALL use reset rst_ni, asynchronous, active-low, and clock clk_i.
REQ-004 Ports SHALL be as follows (name, direction, width, meaning):
 clk_i  in  1  clock
 rst_ni  in  1  async active-low reset
 x_valid_i  in  1  offload request valid
 x_ready_o  out  1  request taken this cycle
 x_instr_i  in  32  offloaded instruction
 x_rs_i  in  3x32  source operands rs1..rs3
 x_rs_valid_i  in  3  operand valid flags
 x_rd_clean_i  in  1  destination register free in core
 x_accept_o  out  1  instruction accepted, qualified by valid&ready
 x_writeback_o  out  1  accepted op will write rd
 x_is_mem_op_o  out  1  accepted op uses the xmem channel
 xmem_valid_o  out  1  memory request valid
 xmem_ready_i  in  1  memory request taken
 xmem_req_type_o  out  mem_req_type_e  READ or WRITE
 xmem_addr_o  out  32  memory address
 xmem_wdata_o  out  32  store data
 xmem_endoftransaction_o  out  1  last request of instruction
 xmem_rvalid_i  in  1  memory response valid
 xmem_rready_o  out  1  response taken
 xmem_rdata_i  in  32  load data
 xmem_status_i  in  1  1 = success
 x_rvalid_o  out  1  result valid
 x_rready_i  in  1  core takes result
 x_rwaddr_o  out  5  result destination register
 x_rdata_o  out  32  result data

Function
REQ-005 Decode: opcode instr[6:0]=7'b0001011; funct3 000 ADD (rd=rs1+rs2, mod 2^32), 001 XOR (rd=rs1^rs2), 010 LW (addr=rs1, rd=load data), 011 SW (addr=rs1, wdata=rs2, no writeback); anything else is unsupported.
REQ-006 x_accept_o, x_writeback_o and x_is_mem_op_o SHALL be combinational from x_instr_i. Unsupported ops SHALL give accept=0, writeback=0, is_mem_op=0.
REQ-007 Supported ops: x_ready_o=1 only when all of the following hold: the FIFO is not full; x_rs_valid_i[0] is set; x_rs_valid_i[1] is set for ADD, XOR and SW; x_rd_clean_i is set for writeback ops. Unsupported ops: x_ready_o=1 in the same cycle (immediate reject); nothing is stored.
REQ-008 On x_valid_i&x_ready_o&x_accept_o, push {funct3, rd=instr[11:7], rs1, rs2}. Push and pop in the same cycle when full SHALL not be allowed, since ready is already 0 when full.
REQ-009 FSM states IDLE, EXEC, MEM_REQ, MEM_RESP, RESULT.
REQ-010 IDLE with FIFO non-empty: pop the head into the working registers. ADD/XOR go to EXEC with the cycle counter loaded to EXEC_LATENCY-1. LW/SW go to MEM_REQ.
REQ-011 EXEC: decrement the counter each cycle. At 0, latch the ALU result and go to RESULT. ADD/XOR issue exactly EXEC_LATENCY cycles after the pop.
REQ-012 MEM_REQ: xmem_valid_o=1 with stable address, type, wdata and endoftransaction=1. xmem_valid_o SHALL not drop before xmem_ready_i. On the handshake go to MEM_RESP.
REQ-013 MEM_RESP: xmem_rready_o=1. On xmem_rvalid_i, LW with status=1 latches xmem_rdata_i and goes to RESULT. SW goes to IDLE with no result. Any op with status=0 goes to IDLE with no result and sets sticky err_q.
REQ-014 RESULT: x_rvalid_o=1 with stable rwaddr and rdata until x_rready_i; then go to IDLE. The FIFO SHALL pop the next instruction no earlier than the cycle after the handshake.
REQ-015 Results SHALL return in offload order; only one instruction executes at a time.
REQ-016 xmem_rready_o SHALL be 0 outside MEM_RESP. xmem_valid_o SHALL be 0 outside MEM_REQ. x_rvalid_o SHALL be 0 outside RESULT.
REQ-017 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full and empty are distinguished by an extra pointer bit.

Reset
REQ-018 Reset SHALL set: FSM to IDLE, FIFO empty, counter 0, err_q 0, data registers 0.
REQ-019 Output values under reset: all valid/ready outputs 0; x_ready_o follows REQ-007 with an empty FIFO.
REQ-020 Reset mid-operation SHALL drop all in-flight and queued instructions with no result issued.

Verification
REQ-021 Test ADD: rs1=5, rs2=7, rd=3, EXEC_LATENCY=3, rready held 1 -> x_rvalid_o rises 3 cycles after the pop, rwaddr=3, rdata=12.
REQ-022 Test unsupported op: x_valid_i with funct3=111 -> x_ready_o=1 and x_accept_o=0 in the same cycle; FIFO empty; no rvalid.
REQ-023 Test LW: rs1=0x100; xmem_ready_i delayed 2 cycles; rdata=0xDEADBEEF -> xmem_valid_o held 3 cycles with addr=0x100, type READ; x_rvalid_o then carries 0xDEADBEEF.
REQ-024 Test full FIFO: FIFO_DEPTH=2, rready=0, issue 4 ADDs -> 1 instruction in RESULT, 2 in the FIFO, x_ready_o=0 for the 4th; after rready=1, all 4 results return in order.
REQ-025 Test operand not ready: ADD with x_rs_valid_i[1]=0 -> x_ready_o=0 until it is set; SW -> no x_rvalid_o, FSM returns to IDLE.
REQ-026 Test reset during MEM_REQ: all outputs go to 0; after release, a new ADD completes normally.

Source files
------------

// File: rtl/cv32e40p_x_acc_adapter.sv
// Offload adapter for a small custom accelerator on the CV32E40P X interface.
// Accepted instructions are queued in a FIFO and executed one at a time,
// either in a fixed-latency ALU (ADD/XOR) or through the xmem channel (LW/SW).
// Results come back to the core in offload order.

package cv32e40p_x_acc_pkg;
  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } mem_req_type_e;
endpackage

module cv32e40p_x_acc_adapter
  import cv32e40p_x_acc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 2,
  parameter int unsigned EXEC_LATENCY = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 x_valid_i,
  output logic                 x_ready_o,
  input  logic [31:0]          x_instr_i,
  input  logic [2:0][31:0]     x_rs_i,
  input  logic [2:0]           x_rs_valid_i,
  input  logic                 x_rd_clean_i,
  output logic                 x_accept_o,
  output logic                 x_writeback_o,
  output logic                 x_is_mem_op_o,
  output logic                 xmem_valid_o,
  input  logic                 xmem_ready_i,
  output mem_req_type_e        xmem_req_type_o,
  output logic [31:0]          xmem_addr_o,
  output logic [31:0]          xmem_wdata_o,
  output logic                 xmem_endoftransaction_o,
  input  logic                 xmem_rvalid_i,
  output logic                 xmem_rready_o,
  input  logic [31:0]          xmem_rdata_i,
  input  logic                 xmem_status_i,
  output logic                 x_rvalid_o,
  input  logic                 x_rready_i,
  output logic [4:0]           x_rwaddr_o,
  output logic [31:0]          x_rdata_o
);

  localparam logic [6:0] OPCODE = 7'b0001011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b011;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = (EXEC_LATENCY > 1) ? $clog2(EXEC_LATENCY) : 1;
  localparam int unsigned ENT_W = 3 + 5 + 32 + 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EXEC     = 3'd1,
    MEM_REQ  = 3'd2,
    MEM_RESP = 3'd3,
    RESULT   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [ENT_W-1:0]   fifo_q [FIFO_DEPTH];
  logic [PTR_W:0]     wptr_q, rptr_q;
  logic [2:0]         op_q;
  logic [4:0]         rd_q;
  logic [31:0]        a_q, b_q, res_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;

  logic [2:0]         f3_s;
  logic               supported_s, needs_rs2_s, writes_rd_s;
  logic               full_s, empty_s, push_s, pop_s;
  logic [ENT_W-1:0]   head_s;
  logic               unused_s;

  assign f3_s = x_instr_i[14:12];

  // Decode the offered instruction into accept / writeback / memory flags.
  always_comb begin
    supported_s   = (x_instr_i[6:0] == OPCODE) && (f3_s[2] == 1'b0);
    needs_rs2_s   = (f3_s != F3_LW);
    writes_rd_s   = supported_s && (f3_s != F3_SW);
    x_accept_o    = supported_s;
    x_writeback_o = writes_rd_s;
    x_is_mem_op_o = supported_s && f3_s[1];
  end

  // Handshake: unsupported ops are rejected at once, supported ones wait for room and operands.
  always_comb begin
    x_ready_o = 1'b1;
    if (supported_s) begin
      x_ready_o = !full_s && x_rs_valid_i[0] && (x_rs_valid_i[1] || !needs_rs2_s) &&
                  (x_rd_clean_i || !writes_rd_s);
    end else begin
      x_ready_o = 1'b1;
    end
  end

  assign full_s  = (wptr_q[PTR_W] != rptr_q[PTR_W]) && (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  assign empty_s = (wptr_q == rptr_q);
  assign push_s  = x_valid_i && x_ready_o && x_accept_o;
  assign pop_s   = (state_q == IDLE) && !empty_s;
  assign head_s  = fifo_q[rptr_q[PTR_W-1:0]];

  // Instruction FIFO storage and wrap-around pointers with an extra lap bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (push_s) begin
        fifo_q[wptr_q[PTR_W-1:0]] <= {f3_s, x_instr_i[11:7], x_rs_i[0], x_rs_i[1]};
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop_s) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    state_d                 = state_q;
    xmem_valid_o            = 1'b0;
    xmem_rready_o           = 1'b0;
    xmem_endoftransaction_o = 1'b0;
    x_rvalid_o              = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_s) begin
          state_d = head_s[ENT_W-2] ? MEM_REQ : EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          state_d = RESULT;
        end else begin
          state_d = EXEC;
        end
      end
      MEM_REQ: begin
        xmem_valid_o            = 1'b1;
        xmem_endoftransaction_o = 1'b1;
        if (xmem_ready_i) begin
          state_d = MEM_RESP;
        end else begin
          state_d = MEM_REQ;
        end
      end
      MEM_RESP: begin
        xmem_rready_o = 1'b1;
        if (xmem_rvalid_i) begin
          state_d = (xmem_status_i && (op_q == F3_LW)) ? RESULT : IDLE;
        end else begin
          state_d = MEM_RESP;
        end
      end
      RESULT: begin
        x_rvalid_o = 1'b1;
        if (x_rready_i) begin
          state_d = IDLE;
        end else begin
          state_d = RESULT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Working registers: load on pop, count down in EXEC, capture ALU or load result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q  <= '0;
      rd_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty_s) begin
            op_q  <= head_s[ENT_W-1 -: 3];
            rd_q  <= head_s[ENT_W-4 -: 5];
            a_q   <= head_s[63:32];
            b_q   <= head_s[31:0];
            cnt_q <= CNT_W'(EXEC_LATENCY - 1);
          end
        end
        EXEC: begin
          if (cnt_q == '0) begin
            res_q <= (op_q == F3_ADD) ? (a_q + b_q) : (a_q ^ b_q);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        MEM_RESP: begin
          if (xmem_rvalid_i) begin
            if (!xmem_status_i) begin
              err_q <= 1'b1;
            end else if (op_q == F3_LW) begin
              res_q <= xmem_rdata_i;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign xmem_req_type_o = (op_q == F3_SW) ? WRITE : READ;
  assign xmem_addr_o     = a_q;
  assign xmem_wdata_o    = b_q;
  assign x_rwaddr_o      = rd_q;
  assign x_rdata_o       = res_q;

  // Operand slot 3, its valid flag and upper instruction bits are not used by this accelerator.
  assign unused_s = ^{x_instr_i[31:15], x_rs_i[2], x_rs_valid_i[2], err_q};

endmodule

// File: tb/tb_cv32e40p_x_acc_adapter.sv
// Randomized self-checking bench for cv32e40p_x_acc_adapter with an in-order result model.
module tb_cv32e40p_x_acc_adapter;
  import cv32e40p_x_acc_pkg::*;

  logic clk = 1'b0;
  logic rst_ni;
  logic x_valid_i, x_ready_o, x_rd_clean_i, x_accept_o, x_writeback_o, x_is_mem_op_o;
  logic [31:0] x_instr_i;
  logic [2:0][31:0] x_rs_i;
  logic [2:0] x_rs_valid_i;
  logic xmem_valid_o, xmem_ready_i, xmem_endoftransaction_o, xmem_rvalid_i, xmem_rready_o, xmem_status_i;
  mem_req_type_e xmem_req_type_o;
  logic [31:0] xmem_addr_o, xmem_wdata_o, xmem_rdata_i;
  logic x_rvalid_o, x_rready_i;
  logic [4:0] x_rwaddr_o;
  logic [31:0] x_rdata_o;

  always #5 clk = ~clk;

  cv32e40p_x_acc_adapter #(.FIFO_DEPTH(2), .EXEC_LATENCY(3)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .x_valid_i(x_valid_i), .x_ready_o(x_ready_o),
    .x_instr_i(x_instr_i), .x_rs_i(x_rs_i), .x_rs_valid_i(x_rs_valid_i), .x_rd_clean_i(x_rd_clean_i),
    .x_accept_o(x_accept_o), .x_writeback_o(x_writeback_o), .x_is_mem_op_o(x_is_mem_op_o),
    .xmem_valid_o(xmem_valid_o), .xmem_ready_i(xmem_ready_i), .xmem_req_type_o(xmem_req_type_o),
    .xmem_addr_o(xmem_addr_o), .xmem_wdata_o(xmem_wdata_o), .xmem_endoftransaction_o(xmem_endoftransaction_o),
    .xmem_rvalid_i(xmem_rvalid_i), .xmem_rready_o(xmem_rready_o), .xmem_rdata_i(xmem_rdata_i),
    .xmem_status_i(xmem_status_i), .x_rvalid_o(x_rvalid_o), .x_rready_i(x_rready_i),
    .x_rwaddr_o(x_rwaddr_o), .x_rdata_o(x_rdata_o)
  );

  localparam logic [2:0] ADD = 3'b000, XOR = 3'b001, LW = 3'b010, SW = 3'b011;

  int checks = 0;
  int failures = 0;

  typedef struct packed { logic [4:0] rd; logic [31:0] data; } res_t;
  typedef struct packed { mem_req_type_e typ; logic [31:0] addr; logic [31:0] wdata; } memreq_t;
  res_t    exp_q[$];
  memreq_t exp_mem_q[$];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] resp_mem  [logic [31:0]];

  // memory responder and result-acceptance knobs
  bit req_active, resp_pending, rr_rand;
  int req_wait, cur_delay, rsp_wait;
  int mem_delay = -1;
  logic mem_status = 1'b1;
  logic [31:0] resp_data;

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [4:0] rd);
    logic [31:0] v;
    v = $urandom;
    v[6:0] = 7'b0001011;
    v[14:12] = f3;
    v[11:7] = rd;
    return v;
  endfunction

  // Reference model: what an accepted instruction must eventually produce.
  task automatic model_push(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    memreq_t m;
    r.rd = rd;
    case (f3)
      ADD: begin r.data = a + b; exp_q.push_back(r); end
      XOR: begin r.data = a ^ b; exp_q.push_back(r); end
      LW: begin
        m.typ = READ; m.addr = a; m.wdata = 32'h0; exp_mem_q.push_back(m);
        r.data = model_mem.exists(a) ? model_mem[a] : mem_default(a);
        if (mem_status) exp_q.push_back(r);
      end
      SW: begin
        m.typ = WRITE; m.addr = a; m.wdata = b; exp_mem_q.push_back(m);
        model_mem[a] = b;
      end
      default: begin end
    endcase
  endtask

  // One clock: drive memory side, score handshakes completing at the coming edge, advance.
  task automatic step();
    res_t e;
    memreq_t m;
    if (rr_rand) x_rready_i = 1'($urandom_range(0, 1));
    xmem_ready_i = 1'b0;
    if (xmem_valid_o) begin
      if (!req_active) begin
        req_active = 1'b1;
        req_wait = 0;
        cur_delay = (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
      end
      xmem_ready_i = (req_wait >= cur_delay);
      req_wait++;
    end
    xmem_rvalid_i = 1'b0;
    if (resp_pending && xmem_rready_o) begin
      if (rsp_wait == 0) xmem_rvalid_i = 1'b1;
      else rsp_wait--;
    end
    xmem_rdata_i = xmem_rvalid_i ? resp_data : $urandom;
    xmem_status_i = mem_status;
    if (x_rvalid_o && x_rready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL result_unexpected: got rd=%0d data=%h, required no result", x_rwaddr_o, x_rdata_o);
      end else begin
        e = exp_q.pop_front();
        if (x_rwaddr_o !== e.rd || x_rdata_o !== e.data) begin
          failures++;
          $display("FAIL result: got rd=%0d data=%h, required rd=%0d data=%h", x_rwaddr_o, x_rdata_o, e.rd, e.data);
        end
      end
    end
    if (xmem_valid_o && xmem_ready_i) begin
      req_active = 1'b0;
      checks++;
      if (exp_mem_q.size() == 0) begin
        failures++;
        $display("FAIL mem_req_unexpected: got addr=%h, required no request", xmem_addr_o);
      end else begin
        m = exp_mem_q.pop_front();
        if (xmem_req_type_o !== m.typ || xmem_addr_o !== m.addr || xmem_endoftransaction_o !== 1'b1 ||
            (m.typ == WRITE && xmem_wdata_o !== m.wdata)) begin
          failures++;
          $display("FAIL mem_req: got type=%0d addr=%h wdata=%h eot=%b, required type=%0d addr=%h wdata=%h eot=1",
                   xmem_req_type_o, xmem_addr_o, xmem_wdata_o, xmem_endoftransaction_o, m.typ, m.addr, m.wdata);
        end
        if (m.typ == WRITE) begin
          resp_mem[m.addr] = m.wdata;
          resp_data = 32'h0;
        end else begin
          resp_data = resp_mem.exists(m.addr) ? resp_mem[m.addr] : mem_default(m.addr);
        end
        resp_pending = 1'b1;
        rsp_wait = int'($urandom_range(0, 2));
      end
    end
    if (xmem_rvalid_i && xmem_rready_o) resp_pending = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic offload(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    bit done = 1'b0;
    x_valid_i = 1'b1;
    x_instr_i = mk_instr(f3, rd);
    x_rs_i[0] = a; x_rs_i[1] = b; x_rs_i[2] = $urandom;
    x_rs_valid_i = {1'($urandom_range(0, 1)), 2'b11};
    x_rd_clean_i = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      if (x_ready_o) begin
        if (x_accept_o) model_push(f3, rd, a, b);
        done = 1'b1;
      end
      step();
    end
    x_valid_i = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL offload_timeout: got x_ready_o=0 for 200 cycles, required 1");
    end
  endtask

  task automatic drain(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      if (exp_q.size() == 0 && exp_mem_q.size() == 0 && !resp_pending) done = 1'b1;
      else step();
    end
    repeat (4) step();
    checks++;
    if (!done || exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d results and %0d mem requests outstanding, required 0", exp_q.size(), exp_mem_q.size());
    end
  endtask

  task automatic clear_model();
    exp_q.delete(); exp_mem_q.delete(); model_mem.delete(); resp_mem.delete();
    req_active = 1'b0; resp_pending = 1'b0;
    xmem_ready_i = 1'b0; xmem_rvalid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; x_valid_i = 1'b0; x_instr_i = 32'h0; x_rs_i = '0; x_rs_valid_i = 3'b000;
    x_rd_clean_i = 1'b0; x_rready_i = 1'b0; xmem_rdata_i = 32'h0; xmem_status_i = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (x_rvalid_o !== 1'b0) begin failures++; $display("FAIL reset_rvalid: got %b required 0", x_rvalid_o); end
    checks++; if (xmem_valid_o !== 1'b0) begin failures++; $display("FAIL reset_xmem_valid: got %b required 0", xmem_valid_o); end
    checks++; if (xmem_rready_o !== 1'b0) begin failures++; $display("FAIL reset_xmem_rready: got %b required 0", xmem_rready_o); end
    checks++; if (x_rdata_o !== 32'h0 || xmem_addr_o !== 32'h0) begin failures++; $display("FAIL reset_data: got rdata=%h addr=%h required 0", x_rdata_o, xmem_addr_o); end
    checks++; if (x_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready_unsup: got %b required 1", x_ready_o); end
    x_instr_i = mk_instr(ADD, 5'd1); x_rs_valid_i = 3'b011; x_rd_clean_i = 1'b1;
    #1;
    checks++; if (x_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready_add: got %b required 1", x_ready_o); end
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_decode();
    logic [2:0] f3;
    logic sup;
    x_valid_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      f3 = 3'(k);
      sup = (k < 4);
      x_instr_i = mk_instr(f3, 5'($urandom_range(0, 31)));
      #1;
      checks++;
      if (x_accept_o !== sup || x_writeback_o !== (sup && k != 3) || x_is_mem_op_o !== (sup && k >= 2)) begin
        failures++;
        $display("FAIL decode f3=%0d: got acc=%b wb=%b mem=%b, required acc=%b wb=%b mem=%b", k,
                 x_accept_o, x_writeback_o, x_is_mem_op_o, sup, sup && k != 3, sup && k >= 2);
      end
    end
    x_instr_i[6:0] = 7'b0110011;
    x_instr_i[14:12] = ADD;
    #1;
    checks++; if (x_accept_o !== 1'b0 || x_ready_o !== 1'b1) begin failures++; $display("FAIL decode_opcode: got acc=%b rdy=%b, required acc=0 rdy=1", x_accept_o, x_ready_o); end
  endtask

  task automatic test_unsupported();
    x_valid_i = 1'b1; x_instr_i = mk_instr(3'b111, 5'd4); x_rs_valid_i = 3'b000; x_rd_clean_i = 1'b0;
    #1;
    checks++; if (x_ready_o !== 1'b1 || x_accept_o !== 1'b0) begin failures++; $display("FAIL unsup_handshake: got rdy=%b acc=%b, required rdy=1 acc=0", x_ready_o, x_accept_o); end
    step();
    x_valid_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++; if (x_rvalid_o !== 1'b0 || xmem_valid_o !== 1'b0) begin failures++; $display("FAIL unsup_idle: got rvalid=%b xmem_valid=%b, required 0", x_rvalid_o, xmem_valid_o); end
      step();
    end
  endtask

  task automatic test_add();
    rr_rand = 1'b0; x_rready_i = 1'b1;
    offload(ADD, 5'd3, 32'd5, 32'd7);
    for (int i = 0; i < 4; i++) begin
      checks++; if (x_rvalid_o !== 1'b0) begin failures++; $display("FAIL add_latency cycle %0d: got rvalid=%b required 0", i, x_rvalid_o); end
      step();
    end
    checks++;
    if (x_rvalid_o !== 1'b1 || x_rwaddr_o !== 5'd3 || x_rdata_o !== 32'd12) begin
      failures++;
      $display("FAIL add_result: got rvalid=%b rd=%0d data=%h, required rvalid=1 rd=3 data=0000000c", x_rvalid_o, x_rwaddr_o, x_rdata_o);
    end
    drain(50);
  endtask

  task automatic test_lw();
    int vcnt = 0;
    x_rready_i = 1'b1; mem_delay = 2;
    model_mem[32'h100] = 32'hDEADBEEF; resp_mem[32'h100] = 32'hDEADBEEF;
    offload(LW, 5'd9, 32'h100, $urandom);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      if (xmem_valid_o) begin
        vcnt++;
        checks++;
        if (xmem_addr_o !== 32'h100 || xmem_req_type_o !== READ || xmem_endoftransaction_o !== 1'b1) begin
          failures++;
          $display("FAIL lw_req: got addr=%h type=%0d eot=%b, required addr=00000100 type=0 eot=1", xmem_addr_o, xmem_req_type_o, xmem_endoftransaction_o);
        end
      end
      step();
    end
    checks++; if (vcnt != 3) begin failures++; $display("FAIL lw_valid_cycles: got %0d required 3", vcnt); end
    drain(50);
    mem_delay = -1;
  endtask

  task automatic test_full();
    logic [2:0] f3 [4];
    logic [31:0] a [4], b [4];
    bit seen = 1'b0;
    rr_rand = 1'b0; x_rready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      f3[i] = 3'($urandom_range(0, 1)); a[i] = $urandom; b[i] = $urandom;
    end
    for (int i = 0; i < 3; i++) offload(f3[i], 5'(10 + i), a[i], b[i]);
    for (int i = 0; i < 20 && !seen; i++) begin
      if (x_rvalid_o) seen = 1'b1; else step();
    end
    checks++; if (!seen) begin failures++; $display("FAIL full_rvalid_timeout: got rvalid=0, required 1"); end
    x_valid_i = 1'b1; x_instr_i = mk_instr(f3[3], 5'd13); x_rs_i[0] = a[3]; x_rs_i[1] = b[3];
    x_rs_valid_i = 3'b011; x_rd_clean_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (x_ready_o !== 1'b0) begin failures++; $display("FAIL full_ready: got %b required 0", x_ready_o); end
      checks++;
      if (x_rvalid_o !== 1'b1 || x_rwaddr_o !== exp_q[0].rd || x_rdata_o !== exp_q[0].data) begin
        failures++;
        $display("FAIL full_hold: got rvalid=%b rd=%0d data=%h, required rvalid=1 rd=%0d data=%h", x_rvalid_o, x_rwaddr_o, x_rdata_o, exp_q[0].rd, exp_q[0].data);
      end
      step();
    end
    x_rready_i = 1'b1;
    offload(f3[3], 5'd13, a[3], b[3]);
    drain(100);
  endtask

  task automatic test_operand();
    logic [31:0] addr = 32'h40, wd;
    x_rready_i = 1'b1;
    x_valid_i = 1'b1; x_instr_i = mk_instr(ADD, 5'd5); x_rs_i[0] = $urandom; x_rs_i[1] = $urandom;
    x_rs_valid_i = 3'b001; x_rd_clean_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (x_ready_o !== 1'b0) begin failures++; $display("FAIL operand_wait: got %b required 0", x_ready_o); end
      step();
    end
    x_rs_valid_i = 3'b011;
    #1;
    checks++; if (x_ready_o !== 1'b1) begin failures++; $display("FAIL operand_ready: got %b required 1", x_ready_o); end
    if (x_ready_o) model_push(ADD, 5'd5, x_rs_i[0], x_rs_i[1]);
    step();
    x_valid_i = 1'b0;
    drain(50);
    x_rd_clean_i = 1'b0;
    #1;
    checks++; if (x_ready_o !== 1'b0) begin failures++; $display("FAIL rd_dirty_add: got %b required 0", x_ready_o); end
    x_instr_i = mk_instr(SW, 5'd6);
    #1;
    checks++; if (x_ready_o !== 1'b1) begin failures++; $display("FAIL rd_dirty_sw: got %b required 1", x_ready_o); end
    x_instr_i = mk_instr(LW, 5'd6); x_rs_valid_i = 3'b001; x_rd_clean_i = 1'b1;
    #1;
    checks++; if (x_ready_o !== 1'b1) begin failures++; $display("FAIL lw_no_rs2: got %b required 1", x_ready_o); end
    wd = $urandom;
    offload(SW, 5'd7, addr, wd);
    drain(50);
    checks++; if (x_rvalid_o !== 1'b0 || xmem_valid_o !== 1'b0) begin failures++; $display("FAIL sw_idle: got rvalid=%b xmem_valid=%b, required 0", x_rvalid_o, xmem_valid_o); end
    offload(LW, 5'd8, addr, $urandom);
    drain(50);
  endtask

  task automatic test_mem_error();
    x_rready_i = 1'b1; mem_status = 1'b0;
    offload(LW, 5'd11, 32'h8, $urandom);
    drain(50);
    mem_status = 1'b1;
    offload(XOR, 5'd12, $urandom, $urandom);
    drain(50);
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    x_rready_i = 1'b1; mem_delay = 1000;
    offload(LW, 5'd14, 32'h4, $urandom);
    offload(ADD, 5'd15, $urandom, $urandom);
    for (int i = 0; i < 20 && !seen; i++) begin
      if (xmem_valid_o) seen = 1'b1; else step();
    end
    checks++; if (!seen) begin failures++; $display("FAIL rstmid_no_memreq: got xmem_valid=0, required 1"); end
    rst_ni = 1'b0;
    #1;
    checks++;
    if (xmem_valid_o !== 1'b0 || x_rvalid_o !== 1'b0 || xmem_rready_o !== 1'b0 || xmem_endoftransaction_o !== 1'b0 ||
        xmem_addr_o !== 32'h0 || x_rdata_o !== 32'h0 || x_rwaddr_o !== 5'd0) begin
      failures++;
      $display("FAIL rstmid_outputs: got xv=%b rv=%b rr=%b eot=%b addr=%h data=%h rd=%0d, required all 0",
               xmem_valid_o, x_rvalid_o, xmem_rready_o, xmem_endoftransaction_o, xmem_addr_o, x_rdata_o, x_rwaddr_o);
    end
    clear_model();
    mem_delay = -1;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    step();
    offload(ADD, 5'd16, 32'hFFFF_FFFF, 32'd2);
    drain(50);
  endtask

  task automatic test_random();
    logic [2:0] f3;
    rr_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      offload(f3, 5'($urandom_range(1, 31)),
              (f3[1]) ? {28'h0, 2'($urandom_range(0, 3)), 2'b00} : $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) step();
    end
    drain(3000);
    rr_rand = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_unsupported();
    test_add();
    test_lw();
    test_full();
    test_operand();
    test_mem_error();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
